he_mem_test_sequencer: RTL

// - CSR master that configures, starts, polls and stops the HE-MEM (HE-LB) AFU through its MMIO register map.
// - Sits between a host-side test/control agent (start, config, done) and the AFU CSR slave port.
// - Replaces a hand-scripted MMIO sequence with a deterministic hardware sequence.
// - Reports completion, timeout and AFU errors.

---
 rtl/he_mem_seq_pkg.sv | 47 ++++
 rtl/he_mem_seq_timer.sv | 50 +++++
 rtl/he_mem_test_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/he_mem_seq_pkg.sv
// Shared types and constants for the HE-MEM CSR test sequencer.
package he_mem_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_EDFH,
    S_RD_ESTAT,
    S_EGAP,
    S_WR_SRC,
    S_WR_DST,
    S_WR_NUM,
    S_WR_CFG,
    S_WR_CTL_RUN,
    S_WR_CTL_GO,
    S_RD_STAT,
    S_GAP,
    S_RD_ERR,
    S_WR_CTL_STOP,
    S_FIN
  } seq_state_e;

  // HE-LB register offsets relative to AFU_BASE
  localparam logic [15:0] OFF_SRC     = 16'h0120;
  localparam logic [15:0] OFF_DST     = 16'h0128;
  localparam logic [15:0] OFF_NUM     = 16'h0130;
  localparam logic [15:0] OFF_CTL     = 16'h0138;
  localparam logic [15:0] OFF_CFG     = 16'h0140;
  localparam logic [15:0] OFF_STATUS0 = 16'h0160;
  localparam logic [15:0] OFF_ERROR   = 16'h0170;

  // EMIF feature block offsets relative to EMIF_BASE
  localparam logic [15:0] OFF_EMIF_DFH    = 16'h0000;
  localparam logic [15:0] OFF_EMIF_STATUS = 16'h0008;
  localparam logic [11:0] EMIF_FEAT_ID    = 12'h009;

  // CTL register values: reset released, go, stop
  localparam logic [63:0] CTL_RUN  = 64'h1;
  localparam logic [63:0] CTL_GO   = 64'h3;
  localparam logic [63:0] CTL_STOP = 64'h7;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
  localparam logic [2:0] ERR_AFU      = 3'd2;
  localparam logic [2:0] ERR_FEAT     = 3'd3;
  localparam logic [2:0] ERR_CAL      = 3'd4;

endpackage

// File: rtl/he_mem_seq_timer.sv
// Poll-gap down-counter and timeout up-counter for the HE-MEM sequencer.
module he_mem_seq_timer #(
  parameter int unsigned POLL_GAP    = 64,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic gap_load,
  output logic gap_zero,
  input  logic to_clr,
  input  logic to_en,
  output logic to_expired
);

  localparam logic [31:0] GAP_RELOAD = (POLL_GAP == 0) ? '0 : 32'(POLL_GAP - 1);

  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] to_cnt_q, to_cnt_d;

  assign gap_zero   = (gap_cnt_q == '0);
  assign to_expired = (to_cnt_q >= TIMEOUT_CYC);

  // Gap counter reloads on entry to a wait state and runs down to zero; timeout counter saturates once expired
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    if (gap_load) begin
      gap_cnt_d = GAP_RELOAD;
    end else if (!gap_zero) begin
      gap_cnt_d = gap_cnt_q - 32'd1;
    end
    if (to_clr) begin
      to_cnt_d = '0;
    end else if (to_en && !to_expired) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

endmodule

// File: rtl/he_mem_test_sequencer.sv
// CSR master that configures, starts, polls and stops the HE-MEM (HE-LB) AFU.
// Define HE_MEM_SEQ_EMIF_CAL_CHECK_EN to check the EMIF feature ID and wait
// for memory calibration before touching the AFU.
module he_mem_test_sequencer
  import he_mem_seq_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]  AFU_BASE    = '0,
  parameter logic [ADDR_W-1:0]  EMIF_BASE   = '0,
  parameter int unsigned        NUM_EMIF_CH = 4,
  parameter int unsigned        POLL_GAP    = 64,
  parameter int unsigned        TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       cfg_src_addr,
  input  logic [63:0]       cfg_dst_addr,
  input  logic [31:0]       cfg_num_lines,
  input  logic [31:0]       cfg_mode,
  output logic              csr_req_valid,
  input  logic              csr_req_ready,
  output logic              csr_req_write,
  output logic [ADDR_W-1:0] csr_req_addr,
  output logic [63:0]       csr_req_wdata,
  input  logic              csr_rsp_valid,
  input  logic [63:0]       csr_rsp_rdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err_code,
  output logic [63:0]       status0
);

  localparam logic [63:0] CAL_MASK =
    (NUM_EMIF_CH >= 64) ? '1 : ((64'd1 << NUM_EMIF_CH) - 64'd1);

  seq_state_e  state_q, state_d;
  logic        rd_pend_q, rd_pend_d;
  logic [63:0] src_q, src_d;
  logic [63:0] dst_q, dst_d;
  logic [31:0] num_q, num_d;
  logic [31:0] mode_q, mode_d;
  logic [2:0]  err_q, err_d;
  logic [63:0] status0_q, status0_d;

  logic gap_load, gap_zero, to_clr, to_en, to_expired;
  logic acc, rsp, cal_ok;

  function automatic logic [ADDR_W-1:0] afu_addr(input logic [15:0] off);
    return AFU_BASE + ADDR_W'(off);
  endfunction

  function automatic logic [ADDR_W-1:0] emif_addr(input logic [15:0] off);
    return EMIF_BASE + ADDR_W'(off);
  endfunction

  he_mem_seq_timer #(
    .POLL_GAP    (POLL_GAP),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .gap_load   (gap_load),
    .gap_zero   (gap_zero),
    .to_clr     (to_clr),
    .to_en      (to_en),
    .to_expired (to_expired)
  );

  // Responses only count while a read is outstanding
  assign acc    = csr_req_valid && csr_req_ready;
  assign rsp    = rd_pend_q && csr_rsp_valid;
  assign cal_ok = ((csr_rsp_rdata & CAL_MASK) == CAL_MASK);

  assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done     = (state_q == S_FIN);
  assign err_code = err_q;
  assign status0  = status0_q;

  // Request fields are a pure function of state and latched config, so they hold while stalled
  always_comb begin
    csr_req_valid = 1'b0;
    csr_req_write = 1'b0;
    csr_req_addr  = '0;
    csr_req_wdata = '0;
    case (state_q)
      S_WR_SRC:      begin csr_req_valid = 1'b1; csr_req_write = 1'b1; csr_req_addr = afu_addr(OFF_SRC); csr_req_wdata = src_q; end
      S_WR_DST:      begin csr_req_valid = 1'b1; csr_req_write = 1'b1; csr_req_addr = afu_addr(OFF_DST); csr_req_wdata = dst_q; end
      S_WR_NUM:      begin csr_req_valid = 1'b1; csr_req_write = 1'b1; csr_req_addr = afu_addr(OFF_NUM); csr_req_wdata = {32'h0, num_q}; end
      S_WR_CFG:      begin csr_req_valid = 1'b1; csr_req_write = 1'b1; csr_req_addr = afu_addr(OFF_CFG); csr_req_wdata = {32'h0, mode_q}; end
      S_WR_CTL_RUN:  begin csr_req_valid = 1'b1; csr_req_write = 1'b1; csr_req_addr = afu_addr(OFF_CTL); csr_req_wdata = CTL_RUN; end
      S_WR_CTL_GO:   begin csr_req_valid = 1'b1; csr_req_write = 1'b1; csr_req_addr = afu_addr(OFF_CTL); csr_req_wdata = CTL_GO; end
      S_WR_CTL_STOP: begin csr_req_valid = 1'b1; csr_req_write = 1'b1; csr_req_addr = afu_addr(OFF_CTL); csr_req_wdata = CTL_STOP; end
      S_RD_STAT:     begin csr_req_valid = !rd_pend_q; csr_req_addr = afu_addr(OFF_STATUS0); end
      S_RD_ERR:      begin csr_req_valid = !rd_pend_q; csr_req_addr = afu_addr(OFF_ERROR); end
      S_RD_EDFH:     begin csr_req_valid = !rd_pend_q; csr_req_addr = emif_addr(OFF_EMIF_DFH); end
      S_RD_ESTAT:    begin csr_req_valid = !rd_pend_q; csr_req_addr = emif_addr(OFF_EMIF_STATUS); end
      default: ;
    endcase
  end

  // Next-state, read tracking and result capture
  always_comb begin
    state_d   = state_q;
    rd_pend_d = rd_pend_q;
    src_d     = src_q;
    dst_d     = dst_q;
    num_d     = num_q;
    mode_d    = mode_q;
    err_d     = err_q;
    status0_d = status0_q;
    gap_load  = 1'b0;
    to_clr    = 1'b0;
    to_en     = 1'b0;

    if (acc && !csr_req_write) begin
      rd_pend_d = 1'b1;
    end
    if (rsp) begin
      rd_pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = cfg_src_addr;
          dst_d  = cfg_dst_addr;
          num_d  = cfg_num_lines;
          mode_d = cfg_mode;
          err_d  = ERR_OK;
`ifdef HE_MEM_SEQ_EMIF_CAL_CHECK_EN
          state_d = S_RD_EDFH;
`else
          state_d = S_WR_SRC;
`endif
        end
      end
      // EMIF states are reachable only through the calibration-check entry above
      S_RD_EDFH: begin
        if (rsp) begin
          if (csr_rsp_rdata[11:0] != EMIF_FEAT_ID) begin
            err_d   = ERR_FEAT;
            state_d = S_FIN;
          end else begin
            to_clr  = 1'b1;
            state_d = S_RD_ESTAT;
          end
        end
      end
      S_RD_ESTAT: begin
        to_en = 1'b1;
        if (rsp) begin
          if (cal_ok) begin
            state_d = S_WR_SRC;
          end else if (to_expired) begin
            err_d   = ERR_CAL;
            state_d = S_FIN;
          end else begin
            gap_load = 1'b1;
            state_d  = S_EGAP;
          end
        end
      end
      S_EGAP: begin
        to_en = 1'b1;
        if (to_expired) begin
          err_d   = ERR_CAL;
          state_d = S_FIN;
        end else if (gap_zero) begin
          state_d = S_RD_ESTAT;
        end
      end
      S_WR_SRC:     if (acc) state_d = S_WR_DST;
      S_WR_DST:     if (acc) state_d = S_WR_NUM;
      S_WR_NUM:     if (acc) state_d = S_WR_CFG;
      S_WR_CFG:     if (acc) state_d = S_WR_CTL_RUN;
      S_WR_CTL_RUN: if (acc) state_d = S_WR_CTL_GO;
      S_WR_CTL_GO: begin
        if (acc) begin
          to_clr  = 1'b1;
          state_d = S_RD_STAT;
        end
      end
      // A completing read wins over a timeout reached in the same cycle
      S_RD_STAT: begin
        to_en = 1'b1;
        if (rsp) begin
          status0_d = csr_rsp_rdata;
          if (csr_rsp_rdata[63:32] >= num_q) begin
            state_d = S_RD_ERR;
          end else if (to_expired) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_WR_CTL_STOP;
          end else begin
            gap_load = 1'b1;
            state_d  = S_GAP;
          end
        end
      end
      S_GAP: begin
        to_en = 1'b1;
        if (to_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_WR_CTL_STOP;
        end else if (gap_zero) begin
          state_d = S_RD_STAT;
        end
      end
      S_RD_ERR: begin
        if (rsp) begin
          if (csr_rsp_rdata != '0) begin
            err_d = ERR_AFU;
          end
          state_d = S_WR_CTL_STOP;
        end
      end
      S_WR_CTL_STOP: if (acc) state_d = S_FIN;
      S_FIN:         state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_pend_q <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      num_q     <= '0;
      mode_q    <= '0;
      err_q     <= '0;
      status0_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      num_q     <= num_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      status0_q <= status0_d;
    end
  end

endmodule
